ram_lru_reader: RTL and testbench



---
 rtl/ram_lru_reader.sv | 312 +++++++++++++++++++++++++++++++
 tb/tb_ram_lru_reader.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_lru_reader.sv
// ram_lru_reader
// Consumer-side sequencer for the triple-buffered LRU pixel RAM. A start
// pulse scans one buffer: read addresses 0..DEPTH-1 are issued against the
// RAM read port, and returning words are passed through a small
// first-word-fall-through skid FIFO onto a valid/ready stream. When the last
// word has been accepted downstream, read_done pulses for one cycle so the
// LRU block can swap in the freshest buffer. One GUARD cycle follows before
// a new start is honoured.
//
// Ports
//   clk, nrst       clock, asynchronous active-low reset
//   start_i         single-cycle scan request (honoured in IDLE only)
//   read_addr_o     RAM read address (holds last issued address when idle)
//   read_data_i     RAM read data, valid RD_LATENCY cycles after the address
//   read_done_o     one-cycle pulse: buffer fully consumed
//   out_data_o      pixel word to downstream
//   out_valid_o     out_data_o valid
//   out_ready_i     downstream accepts on out_valid_o & out_ready_i
//   busy_o          scan in progress (FETCH or DRAIN)
//   overrun_cnt_o   (only with RAM_READER_OVERRUN_EN defined) saturating
//                   count of start pulses seen outside IDLE
//
// Optional feature macro: RAM_READER_OVERRUN_EN
module ram_lru_reader #(
    parameter int ADDR_W     = 7,
    parameter int DATA_W     = 24,
    parameter int DEPTH      = 128,
    parameter int RD_LATENCY = 1,
    parameter int FIFO_DEPTH = RD_LATENCY + 2
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic              start_i,
    output logic [ADDR_W-1:0] read_addr_o,
    input  logic [DATA_W-1:0] read_data_i,
    output logic              read_done_o,
    output logic [DATA_W-1:0] out_data_o,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic              busy_o
`ifdef RAM_READER_OVERRUN_EN
    ,
    output logic [15:0]       overrun_cnt_o
`endif
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int AW1   = ADDR_W + 1;
    localparam int CW1   = CNT_W + 1;

    localparam logic [AW1-1:0]   LAST_ADDR  = AW1'(DEPTH - 1);
    localparam logic [CNT_W-1:0] FIFO_FULL  = CNT_W'(FIFO_DEPTH);
    localparam logic [CW1-1:0]   CREDIT_LIM = CW1'(FIFO_DEPTH);
    localparam logic [PTR_W-1:0] PTR_LAST   = PTR_W'(FIFO_DEPTH - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_DRAIN = 3'd2,
        S_DONE  = 3'd3,
        S_GUARD = 3'd4
    } state_t;

    state_t               state_q, state_d;
    logic [AW1-1:0]       addr_cnt_q, addr_cnt_d;
    logic [ADDR_W-1:0]    last_addr_q, last_addr_d;
    logic [RD_LATENCY-1:0] tag_q, tag_d;
    logic [CNT_W-1:0]     in_flight_q, in_flight_d;
    logic [CNT_W-1:0]     fifo_cnt_q, fifo_cnt_d;
    logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
    logic [DATA_W-1:0]    fifo_mem_q [FIFO_DEPTH];
    logic                 busy_q, busy_d;
    logic                 read_done_q, read_done_d;

    logic                 credit_s;
    logic                 issue_s;
    logic                 last_issue_s;
    logic                 push_s;
    logic                 empty_s;
    logic                 full_s;
    logic                 out_valid_s;
    logic [DATA_W-1:0]    out_data_s;
    logic                 pop_s;
    logic                 pop_fifo_s;
    logic                 store_s;

    // Circular pointer increment for a FIFO whose depth need not be a power of two.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (p == PTR_LAST) begin
            return {PTR_W{1'b0}};
        end else begin
            return p + PTR_W'(1);
        end
    endfunction

    // Issue credit, RAM-return tagging and the fall-through stream interface.
    always_comb begin
        push_s       = tag_q[RD_LATENCY-1];
        empty_s      = (fifo_cnt_q == {CNT_W{1'b0}});
        full_s       = (fifo_cnt_q == FIFO_FULL);
        // Reads in flight reserve FIFO space so a returning word always has a slot.
        credit_s     = ({1'b0, in_flight_q} + {1'b0, fifo_cnt_q}) < CREDIT_LIM;
        issue_s      = (state_q == S_FETCH) && credit_s;
        last_issue_s = issue_s && (addr_cnt_q == LAST_ADDR);
        // A word returning into an empty FIFO is presented in the same cycle.
        out_valid_s  = !empty_s || push_s;
        if (!empty_s) begin
            out_data_s = fifo_mem_q[rd_ptr_q];
        end else if (push_s) begin
            out_data_s = read_data_i;
        end else begin
            out_data_s = {DATA_W{1'b0}};
        end
        pop_s      = out_valid_s && out_ready_i;
        pop_fifo_s = pop_s && !empty_s;
        // A word that bypasses straight to an accepting sink is never stored.
        store_s    = push_s && !(empty_s && pop_s);
    end

    // Next-state for FIFO pointers, occupancy, in-flight count and tag pipe.
    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        in_flight_d = in_flight_q;
        fifo_cnt_d  = fifo_cnt_q;
        tag_d       = {RD_LATENCY{1'b0}};

        if (store_s) begin
            wr_ptr_d = ptr_inc(wr_ptr_q);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end

        if (pop_fifo_s) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end

        if (issue_s && !push_s) begin
            in_flight_d = in_flight_q + CNT_W'(1);
        end else if (!issue_s && push_s) begin
            in_flight_d = in_flight_q - CNT_W'(1);
        end else begin
            in_flight_d = in_flight_q;
        end

        if (store_s && !pop_fifo_s) begin
            fifo_cnt_d = fifo_cnt_q + CNT_W'(1);
        end else if (!store_s && pop_fifo_s) begin
            fifo_cnt_d = fifo_cnt_q - CNT_W'(1);
        end else begin
            fifo_cnt_d = fifo_cnt_q;
        end

        tag_d[0] = issue_s;
        for (int i = 1; i < RD_LATENCY; i++) begin
            tag_d[i] = tag_q[i-1];
        end
    end

    // Address counter and the address held on the RAM port between issues.
    always_comb begin
        addr_cnt_d  = addr_cnt_q;
        last_addr_d = last_addr_q;
        if ((state_q == S_IDLE) && start_i) begin
            addr_cnt_d  = {AW1{1'b0}};
            last_addr_d = {ADDR_W{1'b0}};
        end else if (issue_s) begin
            addr_cnt_d  = addr_cnt_q + AW1'(1);
            last_addr_d = addr_cnt_q[ADDR_W-1:0];
        end else begin
            addr_cnt_d  = addr_cnt_q;
            last_addr_d = last_addr_q;
        end
    end

    // Scan sequencer next state plus registered status outputs.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    state_d = S_FETCH;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_FETCH: begin
                if (last_issue_s) begin
                    state_d = S_DRAIN;
                end else begin
                    state_d = S_FETCH;
                end
            end
            S_DRAIN: begin
                // Every address has been issued, so nothing in flight and an
                // empty FIFO means the final word has already been accepted.
                if ((in_flight_q == {CNT_W{1'b0}}) && empty_s) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_DRAIN;
                end
            end
            S_DONE:  state_d = S_GUARD;
            S_GUARD: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        busy_d      = (state_d == S_FETCH) || (state_d == S_DRAIN);
        read_done_d = (state_d == S_DONE);
    end

    // Control and status registers.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q     <= S_IDLE;
            addr_cnt_q  <= {AW1{1'b0}};
            last_addr_q <= {ADDR_W{1'b0}};
            tag_q       <= {RD_LATENCY{1'b0}};
            in_flight_q <= {CNT_W{1'b0}};
            fifo_cnt_q  <= {CNT_W{1'b0}};
            wr_ptr_q    <= {PTR_W{1'b0}};
            rd_ptr_q    <= {PTR_W{1'b0}};
            busy_q      <= 1'b0;
            read_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_cnt_q  <= addr_cnt_d;
            last_addr_q <= last_addr_d;
            tag_q       <= tag_d;
            in_flight_q <= in_flight_d;
            fifo_cnt_q  <= fifo_cnt_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            busy_q      <= busy_d;
            read_done_q <= read_done_d;
        end
    end

    // Skid FIFO storage.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_mem_q[i] <= {DATA_W{1'b0}};
            end
        end else if (store_s) begin
            fifo_mem_q[wr_ptr_q] <= read_data_i;
        end else begin
            fifo_mem_q <= fifo_mem_q;
        end
    end

`ifdef RAM_READER_OVERRUN_EN
    logic [15:0] overrun_q;

    // Saturating count of start pulses that arrive while a scan is not idle.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            overrun_q <= 16'h0000;
        end else if (start_i && (state_q != S_IDLE) && (overrun_q != 16'hFFFF)) begin
            overrun_q <= overrun_q + 16'h0001;
        end else begin
            overrun_q <= overrun_q;
        end
    end

    assign overrun_cnt_o = overrun_q;
`endif

    assign read_addr_o = issue_s ? addr_cnt_q[ADDR_W-1:0] : last_addr_q;
    assign out_valid_o = out_valid_s;
    assign out_data_o  = out_data_s;
    assign read_done_o = read_done_q;
    assign busy_o      = busy_q;

    ram_lru_reader_chk #(
        .CNT_W      (CNT_W),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_chk (
        .clk        (clk),
        .nrst       (nrst),
        .push_i     (push_s),
        .full_i     (full_s),
        .fifo_cnt_i (fifo_cnt_q)
    );

endmodule

// ram_lru_reader_chk
// Invariant checks for the reader's skid FIFO: no word may return into a
// full FIFO, and occupancy never exceeds its depth.
// Ports: clk, nrst, push_i (word returning from RAM), full_i (FIFO full),
// fifo_cnt_i (current occupancy).
module ram_lru_reader_chk #(
    parameter int CNT_W      = 3,
    parameter int FIFO_DEPTH = 3
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic             push_i,
    input  logic             full_i,
    input  logic [CNT_W-1:0] fifo_cnt_i
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(FIFO_DEPTH);

    a_no_overflow: assert property (@(posedge clk) disable iff (!nrst) !(push_i && full_i));
    a_cnt_bound:   assert property (@(posedge clk) disable iff (!nrst) fifo_cnt_i <= CNT_MAX);

endmodule

// File: tb/tb_ram_lru_reader.sv
// Self-checking bench for ram_lru_reader: a behavioural RAM with one cycle of
// read latency feeds the reader; expected words are queued when a scan is
// started and compared against every accepted output handshake.
module tb_ram_lru_reader;

    localparam int ADDR_W     = 7;
    localparam int DATA_W     = 24;
    localparam int DEPTH      = 128;
    localparam int RD_LATENCY = 1;
    localparam int FIFO_DEPTH = 3;

    logic              clk = 1'b0;
    logic              nrst = 1'b0;
    logic              start = 1'b0;
    logic              out_ready = 1'b0;
    logic [ADDR_W-1:0] read_addr;
    logic [DATA_W-1:0] read_data;
    logic              read_done;
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              busy;
`ifdef RAM_READER_OVERRUN_EN
    logic [15:0]       overrun_cnt;
`endif

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] ram_q;
    logic [DATA_W-1:0] exp_q [$];
    logic [DATA_W-1:0] exp_w;
    bit                mon_en = 1'b0;
    int                hs_cnt = 0;
    int                total = 0;
    int                bad = 0;

    ram_lru_reader #(
        .ADDR_W     (ADDR_W),
        .DATA_W     (DATA_W),
        .DEPTH      (DEPTH),
        .RD_LATENCY (RD_LATENCY),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk         (clk),
        .nrst        (nrst),
        .start_i     (start),
        .read_addr_o (read_addr),
        .read_data_i (read_data),
        .read_done_o (read_done),
        .out_data_o  (out_data),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .busy_o      (busy)
`ifdef RAM_READER_OVERRUN_EN
        ,
        .overrun_cnt_o (overrun_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Synchronous RAM model: one cycle from address to data.
    always @(posedge clk) ram_q <= mem[read_addr];
    assign read_data = ram_q;

    // Scoreboard: every accepted word must be the next queued expectation.
    always @(negedge clk) begin
        if (mon_en && out_valid && out_ready) begin
            hs_cnt++;
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL sb_extra_word: got %06h required no further word", out_data);
            end else begin
                exp_w = exp_q.pop_front();
                if (out_data !== exp_w) begin
                    bad++;
                    $display("FAIL sb_word%0d: got %06h required %06h", hs_cnt - 1, out_data, exp_w);
                end
            end
        end
    end

    task automatic fill_mem();
        for (int i = 0; i < DEPTH; i++) mem[i] = DATA_W'($urandom);
    endtask

    task automatic load_expect();
        exp_q.delete();
        for (int i = 0; i < DEPTH; i++) exp_q.push_back(mem[i]);
        hs_cnt = 0;
    endtask

    // Start high for exactly one cycle; returns one delta after cycle 1 begins.
    task automatic pulse_start();
        @(posedge clk); #1; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        #1;
        total++; if (read_addr !== 7'd0) begin bad++; $display("FAIL rst_read_addr: got %0d required 0", read_addr); end
        total++; if (read_done !== 1'b0) begin bad++; $display("FAIL rst_read_done: got %b required 0", read_done); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid: got %b required 0", out_valid); end
        total++; if (out_data !== 24'd0) begin bad++; $display("FAIL rst_out_data: got %06h required 0", out_data); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy: got %b required 0", busy); end
`ifdef RAM_READER_OVERRUN_EN
        total++; if (overrun_cnt !== 16'd0) begin bad++; $display("FAIL rst_overrun: got %0d required 0", overrun_cnt); end
`endif
        nrst = 1'b1;
    endtask

    task automatic test_basic_scan();
        int first_valid = -1;
        int dones = 0;
        int addr_bad = 0;
        logic [ADDR_W-1:0] ea;
        fill_mem(); load_expect();
        out_ready = 1'b1; mon_en = 1'b1;
        pulse_start();
        for (int cyc = 1; cyc <= 200; cyc++) begin
            @(negedge clk); #1;
            if (cyc == 1) begin
                total++; if (busy !== 1'b1) begin bad++; $display("FAIL basic_busy_c1: got %b required 1", busy); end
            end
            if (cyc <= DEPTH) begin
                ea = ADDR_W'(cyc - 1);
                if (read_addr !== ea) begin
                    addr_bad++;
                    $display("FAIL basic_read_addr c%0d: got %0d required %0d", cyc, read_addr, ea);
                end
            end
            if (out_valid && first_valid < 0) first_valid = cyc;
            if (read_done) begin
                dones++;
                total++; if (busy !== 1'b0) begin bad++; $display("FAIL basic_busy_at_done: got %b required 0", busy); end
                total++; if (hs_cnt !== DEPTH) begin bad++; $display("FAIL basic_words_at_done: got %0d required %0d", hs_cnt, DEPTH); end
            end
        end
        total++; if (addr_bad != 0) begin bad++; $display("FAIL basic_addr_seq: got %0d wrong cycles required 0", addr_bad); end
        total++; if (first_valid != RD_LATENCY + 1) begin bad++; $display("FAIL basic_first_valid: got cycle %0d required %0d", first_valid, RD_LATENCY + 1); end
        total++; if (dones != 1) begin bad++; $display("FAIL basic_done_pulses: got %0d required 1", dones); end
        total++; if (exp_q.size() != 0) begin bad++; $display("FAIL basic_left_over: got %0d words pending required 0", exp_q.size()); end
    endtask

    task automatic test_backpressure();
        int dones = 0;
        int max_fill = 0;
        int done_cyc = -1;
        fill_mem(); load_expect();
        out_ready = 1'b1; mon_en = 1'b1;
        pulse_start();
        for (int cyc = 1; cyc <= 2000; cyc++) begin
            @(negedge clk); #1;
            if (int'(dut.fifo_cnt_q) > max_fill) max_fill = int'(dut.fifo_cnt_q);
            if (read_done) begin
                dones++;
                if (done_cyc < 0) done_cyc = cyc;
                total++; if (hs_cnt !== DEPTH) begin bad++; $display("FAIL bp_words_at_done: got %0d required %0d", hs_cnt, DEPTH); end
            end
            @(posedge clk); #1;
            out_ready = ($urandom_range(0, 1) == 1);
            if (done_cyc >= 0 && cyc > done_cyc + 3) break;
        end
        out_ready = 1'b1;
        total++; if (done_cyc < 0) begin bad++; $display("FAIL bp_timeout: got no read_done required one within 2000 cycles"); end
        total++; if (max_fill > FIFO_DEPTH) begin bad++; $display("FAIL bp_fifo_fill: got %0d required <= %0d", max_fill, FIFO_DEPTH); end
        total++; if (dones != 1) begin bad++; $display("FAIL bp_done_pulses: got %0d required 1", dones); end
        total++; if (exp_q.size() != 0) begin bad++; $display("FAIL bp_left_over: got %0d words pending required 0", exp_q.size()); end
    endtask

    task automatic test_stalled_sink();
        int max_addr = 0;
        int dones = 0;
        int cyc = 0;
        fill_mem(); load_expect();
        out_ready = 1'b0; mon_en = 1'b1;
        pulse_start();
        repeat (12) begin
            @(negedge clk); #1;
            if (int'(read_addr) > max_addr) max_addr = int'(read_addr);
        end
        total++; if (read_addr !== 7'd2) begin bad++; $display("FAIL stall_read_addr: got %0d required 2", read_addr); end
        total++; if (max_addr != 2) begin bad++; $display("FAIL stall_max_addr: got %0d required 2", max_addr); end
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL stall_out_valid: got %b required 1", out_valid); end
        total++; if (out_data !== mem[0]) begin bad++; $display("FAIL stall_head: got %06h required %06h", out_data, mem[0]); end
        @(posedge clk); #1; out_ready = 1'b1;
        while (dones == 0 && cyc < 300) begin
            @(negedge clk); #1;
            cyc++;
            if (read_done) dones++;
        end
        total++; if (dones != 1) begin bad++; $display("FAIL stall_done: got %0d pulses required 1", dones); end
        total++; if (hs_cnt != DEPTH) begin bad++; $display("FAIL stall_words: got %0d required %0d", hs_cnt, DEPTH); end
    endtask

    task automatic test_start_while_busy();
        int dones = 0;
        int done_cyc = -1;
        bit busy_after = 1'b0;
        fill_mem(); load_expect();
        out_ready = 1'b1; mon_en = 1'b1;
        pulse_start();
        for (int cyc = 1; cyc <= 300; cyc++) begin
            @(negedge clk); #1;
            if (read_done) begin
                dones++;
                if (done_cyc < 0) done_cyc = cyc;
            end
            if (done_cyc >= 0 && cyc > done_cyc && busy) busy_after = 1'b1;
`ifdef RAM_READER_OVERRUN_EN
            if (cyc == 51) begin
                total++; if (overrun_cnt !== 16'd1) begin bad++; $display("FAIL busy_overrun_mid: got %0d required 1", overrun_cnt); end
            end
`endif
            @(posedge clk); #1;
            // Second start in cycle 50 (mid-scan), third in the GUARD cycle.
            start = (cyc == 49) || (done_cyc >= 0 && cyc == done_cyc);
            if (done_cyc >= 0 && cyc >= done_cyc + 12) break;
        end
        start = 1'b0;
        total++; if (dones != 1) begin bad++; $display("FAIL busy_done_pulses: got %0d required 1", dones); end
        total++; if (busy_after) begin bad++; $display("FAIL busy_restart: got busy after done required idle"); end
        total++; if (read_addr !== 7'd127) begin bad++; $display("FAIL busy_final_addr: got %0d required 127", read_addr); end
        total++; if (hs_cnt != DEPTH) begin bad++; $display("FAIL busy_words: got %0d required %0d", hs_cnt, DEPTH); end
`ifdef RAM_READER_OVERRUN_EN
        total++; if (overrun_cnt !== 16'd2) begin bad++; $display("FAIL busy_overrun_end: got %0d required 2", overrun_cnt); end
`endif
    endtask

    task automatic test_frame_swap();
        for (int f = 0; f < 2; f++) begin
            int dones = 0;
            int cyc = 0;
            fill_mem(); load_expect();
            out_ready = 1'b1; mon_en = 1'b1;
            pulse_start();
            while (cyc < 300 && !(dones > 0 && cyc > 140)) begin
                @(negedge clk); #1;
                cyc++;
                if (read_done) dones++;
            end
            total++; if (dones != 1) begin bad++; $display("FAIL frame%0d_done: got %0d pulses required 1", f, dones); end
            total++; if (exp_q.size() != 0) begin bad++; $display("FAIL frame%0d_left_over: got %0d required 0", f, exp_q.size()); end
        end
    endtask

    task automatic test_reset_mid_scan();
        int cyc = 0;
        int dones = 0;
        bit stray = 1'b0;
        fill_mem(); load_expect();
        out_ready = 1'b1; mon_en = 1'b1;
        pulse_start();
        while (hs_cnt < 60 && cyc < 300) begin
            @(negedge clk); #1;
            cyc++;
        end
        total++; if (hs_cnt < 60) begin bad++; $display("FAIL rmid_timeout: got %0d words required 60", hs_cnt); end
        nrst = 1'b0;
        #1;
        total++; if (read_addr !== 7'd0) begin bad++; $display("FAIL rmid_read_addr: got %0d required 0", read_addr); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rmid_out_valid: got %b required 0", out_valid); end
        total++; if (out_data !== 24'd0) begin bad++; $display("FAIL rmid_out_data: got %06h required 0", out_data); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rmid_busy: got %b required 0", busy); end
        mon_en = 1'b0; exp_q.delete();
        repeat (3) begin @(negedge clk); #1; if (read_done) stray = 1'b1; end
        nrst = 1'b1;
        repeat (5) begin @(negedge clk); #1; if (read_done || busy) stray = 1'b1; end
        total++; if (stray) begin bad++; $display("FAIL rmid_stray_done: got activity after reset required none"); end
        load_expect(); mon_en = 1'b1;
        pulse_start();
        @(negedge clk); #1;
        total++; if (read_addr !== 7'd0) begin bad++; $display("FAIL rmid_restart_addr: got %0d required 0", read_addr); end
        cyc = 0;
        while (dones == 0 && cyc < 300) begin
            @(negedge clk); #1;
            cyc++;
            if (read_done) dones++;
        end
        total++; if (dones != 1) begin bad++; $display("FAIL rmid_rescan_done: got %0d required 1", dones); end
        total++; if (hs_cnt != DEPTH) begin bad++; $display("FAIL rmid_rescan_words: got %0d required %0d", hs_cnt, DEPTH); end
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) mem[i] = 24'd0;
        test_reset();
        test_basic_scan();
        test_backpressure();
        test_stalled_sink();
        test_start_while_busy();
        test_frame_swap();
        test_reset_mid_scan();
        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
